// File: rtl/waveform_capture.sv
// Triggered dual-channel capture buffer for the VGA scope view.
// Waits for a rising-edge level crossing (or timeout), then stores DEPTH decimated sample pairs.
module waveform_capture #(
  parameter int unsigned DEPTH        = 640,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned AUTO_TIMEOUT = 100000
) (
  input  logic              sampler_clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [11:0]       actual_selected_modulation,
  input  logic [11:0]       actual_selected_signal,
  input  logic              arm,
  input  logic              trig_src,
  input  logic [11:0]       trig_level,
  input  logic [7:0]        decim,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [11:0]       rd_mod,
  output logic [11:0]       rd_sig,
  output logic              busy,
  output logic              capture_done,
  output logic              auto_triggered
);

  typedef enum logic [1:0] {StIdle, StWaitTrig, StCapture, StDone} state_e;

  state_e            state_q, state_d;
  logic              trig_src_q, trig_src_d;
  logic [11:0]       level_q, level_d;
  logic [7:0]        decim_q, decim_d;
  logic [11:0]       prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              auto_q, auto_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        decim_cnt_q, decim_cnt_d;
  logic [23:0]       rd_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [23:0]       mem_wdata;
  logic [23:0]       mem_q [DEPTH];

  logic [11:0]       trig_sample;
  logic              level_cross;
  logic              tmo_hit;

  assign trig_sample = trig_src_q ? actual_selected_modulation : actual_selected_signal;
  assign level_cross = prev_valid_q && (prev_q < level_q) && (trig_sample >= level_q);
  assign tmo_hit     = (AUTO_TIMEOUT != 0) && (tmo_q == AUTO_TIMEOUT - 32'd1);
  assign mem_wdata   = {actual_selected_modulation, actual_selected_signal};

  always_comb begin
    state_d      = state_q;
    trig_src_d   = trig_src_q;
    level_d      = level_q;
    decim_d      = decim_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    tmo_d        = tmo_q;
    auto_d       = auto_q;
    wr_addr_d    = wr_addr_q;
    decim_cnt_d  = decim_cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          state_d      = StWaitTrig;
          trig_src_d   = trig_src;
          level_d      = trig_level;
          decim_d      = decim;
          prev_d       = '0;
          prev_valid_d = 1'b0;
          tmo_d        = '0;
          auto_d       = 1'b0;
        end
      end
      StWaitTrig: begin
        if (sample_en) begin
          if (level_cross || tmo_hit) begin
            // The triggering sample itself becomes column 0.
            mem_we      = 1'b1;
            mem_waddr   = '0;
            wr_addr_d   = ADDR_W'(1);
            decim_cnt_d = '0;
            state_d     = StCapture;
            auto_d      = !level_cross;
          end else begin
            prev_d       = trig_sample;
            prev_valid_d = 1'b1;
            tmo_d        = tmo_q + 32'd1;
          end
        end
      end
      StCapture: begin
        if (sample_en) begin
          if (decim_cnt_q == decim_q) begin
            mem_we      = 1'b1;
            wr_addr_d   = wr_addr_q + ADDR_W'(1);
            decim_cnt_d = '0;
            if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
              state_d = StDone;
            end
          end else begin
            decim_cnt_d = decim_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sampler_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      trig_src_q   <= 1'b0;
      level_q      <= '0;
      decim_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      tmo_q        <= '0;
      auto_q       <= 1'b0;
      wr_addr_q    <= '0;
      decim_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      trig_src_q   <= trig_src_d;
      level_q      <= level_d;
      decim_q      <= decim_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      tmo_q        <= tmo_d;
      auto_q       <= auto_d;
      wr_addr_q    <= wr_addr_d;
      decim_cnt_q  <= decim_cnt_d;
    end
  end

  // Buffer contents survive reset so the last frame stays drawable.
  always_ff @(posedge sampler_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge sampler_clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (32'(rd_addr) < DEPTH) begin
      rd_q <= mem_q[rd_addr];
    end else begin
      rd_q <= '0;
    end
  end

  assign rd_mod         = rd_q[23:12];
  assign rd_sig         = rd_q[11:0];
  assign busy           = (state_q == StWaitTrig) || (state_q == StCapture);
  assign capture_done   = (state_q == StDone);
  assign auto_triggered = auto_q;

endmodule

// File: tb/tb_waveform_capture.sv
// Directed bench for waveform_capture: trigger, decimation, auto-trigger, abort and re-arm.
module tb_waveform_capture;

  logic        sampler_clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_en = 1'b0;
  logic [11:0] actual_selected_modulation = '0;
  logic [11:0] actual_selected_signal = '0;
  logic        arm = 1'b0;
  logic        trig_src = 1'b0;
  logic [11:0] trig_level = '0;
  logic [7:0]  decim = '0;
  logic [9:0]  rd_addr = '0;
  logic [11:0] rd_mod, rd_sig;
  logic        busy, capture_done, auto_triggered;

  int total = 0;
  int bad = 0;

  waveform_capture #(
    .DEPTH       (640),
    .ADDR_W      (10),
    .AUTO_TIMEOUT(1000)
  ) dut (
    .sampler_clk               (sampler_clk),
    .reset                     (reset),
    .sample_en                 (sample_en),
    .actual_selected_modulation(actual_selected_modulation),
    .actual_selected_signal    (actual_selected_signal),
    .arm                       (arm),
    .trig_src                  (trig_src),
    .trig_level                (trig_level),
    .decim                     (decim),
    .rd_addr                   (rd_addr),
    .rd_mod                    (rd_mod),
    .rd_sig                    (rd_sig),
    .busy                      (busy),
    .capture_done              (capture_done),
    .auto_triggered            (auto_triggered)
  );

  always #5 sampler_clk = ~sampler_clk;

  task automatic tick();
    @(posedge sampler_clk);
    #1;
  endtask

  task automatic strobe(input logic [11:0] m, input logic [11:0] s);
    actual_selected_modulation = m;
    actual_selected_signal     = s;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_arm(input logic src, input logic [11:0] lvl, input logic [7:0] dec);
    trig_src   = src;
    trig_level = lvl;
    decim      = dec;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic read_buf(input int a, output logic [11:0] m, output logic [11:0] s);
    rd_addr = 10'(a);
    tick();
    m = rd_mod;
    s = rd_sig;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_addr = 10'd5;
    tick();
    tick();
    total++;
    if ({busy, capture_done, auto_triggered, rd_mod, rd_sig} !== 27'd0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b auto=%b mod=%0d sig=%0d want all 0",
               busy, capture_done, auto_triggered, rd_mod, rd_sig);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) strobe(12'd3000, 12'd3000);
    total++;
    if (busy !== 1'b0 || capture_done !== 1'b0) begin
      bad++;
      $display("FAIL idle_strobes: busy=%b done=%b want 0/0", busy, capture_done);
    end
  endtask

  task automatic test_ramp();
    int          ra [5] = '{0, 1, 127, 128, 639};
    logic [11:0] ev [5] = '{12'd2048, 12'd2064, 12'd4080, 12'd0, 12'd4080};
    logic [11:0] m, s;
    do_arm(1'b0, 12'd2048, 8'd0);
    for (int i = 0; i < 768; i++) begin
      // A mid-capture arm with different settings must be ignored.
      if (i == 400) begin
        arm = 1'b1; trig_src = 1'b1; trig_level = 12'd0; decim = 8'd7;
      end
      strobe(12'd4095 - 12'(16 * i), 12'(16 * i));
      arm = 1'b0;
      if (i == 766) begin
        total++;
        if (capture_done !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL ramp_before_last: done=%b busy=%b want 0/1", capture_done, busy);
        end
      end
    end
    total++;
    if (capture_done !== 1'b1 || busy !== 1'b0 || auto_triggered !== 1'b0) begin
      bad++;
      $display("FAIL ramp_done: done=%b busy=%b auto=%b want 1/0/0",
               capture_done, busy, auto_triggered);
    end
    for (int k = 0; k < 5; k++) begin
      read_buf(ra[k], m, s);
      total++;
      if (s !== ev[k]) begin
        bad++;
        $display("FAIL ramp_sig[%0d]: got %0d want %0d", ra[k], s, ev[k]);
      end
    end
    read_buf(0, m, s);
    total++;
    if (m !== 12'd2047) begin
      bad++;
      $display("FAIL ramp_mod[0]: got %0d want 2047", m);
    end
    for (int i = 0; i < 4; i++) strobe(12'd1234, 12'd1234);
    read_buf(0, m, s);
    total++;
    if (s !== 12'd2048 || capture_done !== 1'b1) begin
      bad++;
      $display("FAIL done_hold: sig[0]=%0d done=%b want 2048/1", s, capture_done);
    end
  endtask

  task automatic test_decim();
    int          ra [4] = '{0, 1, 32, 639};
    logic [11:0] ev [4] = '{12'd2048, 12'd2112, 12'd0, 12'd1984};
    logic [11:0] m, s;
    do_arm(1'b0, 12'd2048, 8'd3);
    for (int i = 0; i < 2685; i++) begin
      strobe(12'd4095 - 12'(16 * i), 12'(16 * i));
      if (i == 2683) begin
        total++;
        if (capture_done !== 1'b0) begin
          bad++;
          $display("FAIL decim_before_last: done=%b want 0", capture_done);
        end
      end
    end
    total++;
    if (capture_done !== 1'b1) begin
      bad++;
      $display("FAIL decim_done: done=%b want 1", capture_done);
    end
    for (int k = 0; k < 4; k++) begin
      read_buf(ra[k], m, s);
      total++;
      if (s !== ev[k]) begin
        bad++;
        $display("FAIL decim_sig[%0d]: got %0d want %0d", ra[k], s, ev[k]);
      end
    end
    read_buf(1, m, s);
    total++;
    if (m !== 12'd1983) begin
      bad++;
      $display("FAIL decim_mod[1]: got %0d want 1983", m);
    end
  endtask

  task automatic test_start_above();
    logic [11:0] pre [6] = '{12'd3000, 12'd2500, 12'd1000, 12'd1500, 12'd2047, 12'd2100};
    logic [11:0] m, s;
    do_arm(1'b0, 12'd2048, 8'd0);
    for (int i = 0; i < 6; i++) strobe(12'd0, pre[i]);
    for (int k = 0; k < 639; k++) strobe(12'd0, 12'd2200 + 12'(k));
    total++;
    if (capture_done !== 1'b1) begin
      bad++;
      $display("FAIL above_done: done=%b want 1", capture_done);
    end
    read_buf(0, m, s);
    total++;
    if (s !== 12'd2100) begin
      bad++;
      $display("FAIL above_first: got %0d want 2100", s);
    end
    read_buf(639, m, s);
    total++;
    if (s !== 12'd2838) begin
      bad++;
      $display("FAIL above_last: got %0d want 2838", s);
    end
  endtask

  task automatic test_auto();
    logic [11:0] m, s;
    int          miss;
    do_arm(1'b0, 12'd2048, 8'd0);
    for (int i = 0; i < 999; i++) strobe(12'd100, 12'd100);
    total++;
    if (auto_triggered !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL auto_early: auto=%b busy=%b want 0/1", auto_triggered, busy);
    end
    strobe(12'd100, 12'd100);
    total++;
    if (auto_triggered !== 1'b1) begin
      bad++;
      $display("FAIL auto_fire: auto=%b want 1", auto_triggered);
    end
    for (int i = 0; i < 638; i++) strobe(12'd100, 12'd100);
    total++;
    if (capture_done !== 1'b0) begin
      bad++;
      $display("FAIL auto_before_last: done=%b want 0", capture_done);
    end
    strobe(12'd100, 12'd100);
    total++;
    if (capture_done !== 1'b1) begin
      bad++;
      $display("FAIL auto_done: done=%b want 1", capture_done);
    end
    miss = 0;
    for (int a = 0; a < 640; a++) begin
      read_buf(a, m, s);
      if (m !== 12'd100 || s !== 12'd100) miss++;
    end
    total++;
    if (miss != 0) begin
      bad++;
      $display("FAIL auto_contents: %0d entries differ from 100", miss);
    end
    read_buf(640, m, s);
    total++;
    if (m !== 12'd0 || s !== 12'd0) begin
      bad++;
      $display("FAIL read_oob: mod=%0d sig=%0d want 0/0", m, s);
    end
    // Leaves the DUT armed (signal channel, level 2048, decim 0) for test_abort.
    do_arm(1'b0, 12'd2048, 8'd0);
    total++;
    if (auto_triggered !== 1'b0) begin
      bad++;
      $display("FAIL auto_clear: auto=%b want 0", auto_triggered);
    end
  endtask

  task automatic test_abort();
    logic [11:0] m, s;
    for (int i = 0; i < 428; i++) strobe(12'd0, 12'(16 * i));
    reset = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || capture_done !== 1'b0 || rd_mod !== 12'd0 || rd_sig !== 12'd0) begin
      bad++;
      $display("FAIL abort_reset: busy=%b done=%b mod=%0d sig=%0d want 0", busy, capture_done,
               rd_mod, rd_sig);
    end
    reset = 1'b0;
    do_arm(1'b1, 12'd1000, 8'd1);
    for (int i = 0; i < 1342; i++) begin
      strobe(12'(16 * i), 12'd5);
      if (i == 1340) begin
        total++;
        if (capture_done !== 1'b0) begin
          bad++;
          $display("FAIL rearm_before_last: done=%b want 0", capture_done);
        end
      end
    end
    total++;
    if (capture_done !== 1'b1) begin
      bad++;
      $display("FAIL rearm_done: done=%b want 1", capture_done);
    end
    read_buf(1, m, s);
    total++;
    if (m !== 12'd1040 || s !== 12'd5) begin
      bad++;
      $display("FAIL rearm_data[1]: mod=%0d sig=%0d want 1040/5", m, s);
    end
    do_arm(1'b0, 12'd2048, 8'd0);
    for (int i = 0; i < 768; i++) strobe(12'd9, 12'(16 * i));
    total++;
    if (capture_done !== 1'b1) begin
      bad++;
      $display("FAIL done_rearm_done: done=%b want 1", capture_done);
    end
    read_buf(5, m, s);
    total++;
    if (m !== 12'd9 || s !== 12'd2128) begin
      bad++;
      $display("FAIL done_rearm_data[5]: mod=%0d sig=%0d want 9/2128", m, s);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_decim();
    test_start_above();
    test_auto();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
